// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// video_pkg: shared types and mode constants for the video effect stage
// Rev 1.0 - initial release
// ============================================================================
package video_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } seq_state_t;

  localparam int NUM_MODES_DEFAULT = 4;
  localparam int MODE_W_DEFAULT    = $clog2(NUM_MODES_DEFAULT);

  typedef logic [MODE_W_DEFAULT-1:0] mode_t;

  localparam mode_t MODE_PASS   = mode_t'(0);
  localparam mode_t MODE_INVERT = mode_t'(1);

endpackage
`default_nettype wire

// File: rtl/vsync_edge_detect.sv
`default_nettype none
// ============================================================================
// vsync_edge_detect: registers vsync and flags the first active cycle of a frame
// Rev 1.0 - initial release
// ============================================================================
module vsync_edge_detect #(
  parameter int VSYNC_POL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_start
);

  localparam logic c_active = (VSYNC_POL != 0);

  logic r_vsync_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d1 <= ~c_active;
    end else begin
      r_vsync_d1 <= vsync;
    end
  end

  assign frame_start = (vsync == c_active) && (r_vsync_d1 != c_active);

endmodule
`default_nettype wire

// File: rtl/video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// video_mode_sequencer: frame-synchronous effect mode select with auto-cycle
// Rev 1.0 - initial release
// ============================================================================
module video_mode_sequencer
  import video_pkg::*;
#(
  parameter int NUM_MODES   = 4,
  parameter int MODE_W      = $clog2(NUM_MODES),
  parameter int AUTO_FRAMES = 60,
  parameter int VSYNC_POL   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              cfg_valid,
  input  logic [MODE_W-1:0] cfg_mode,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              auto_en,
  output logic [MODE_W-1:0] mode_out,
  output logic              mode_update,
  output logic              pending,
  output logic [15:0]       frame_cnt
);

  localparam int CNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  c_auto_last = CNT_W'(AUTO_FRAMES - 1);
  localparam logic [MODE_W-1:0] c_mode_last = MODE_W'(NUM_MODES - 1);

  generate
    if (AUTO_FRAMES < 1) begin : g_bad_auto_frames
      $error("AUTO_FRAMES must be at least 1");
    end
    if ((1 << MODE_W) < NUM_MODES) begin : g_bad_mode_w
      $error("MODE_W too narrow for NUM_MODES");
    end
  endgenerate

  seq_state_t        r_state;
  logic [MODE_W-1:0] r_req_mode;
  logic [CNT_W-1:0]  r_auto_cnt;
  logic              w_frame_start;
  logic              w_mode_legal;

  vsync_edge_detect #(
    .VSYNC_POL (VSYNC_POL)
  ) u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .frame_start (w_frame_start)
  );

  assign w_mode_legal = ({{(32-MODE_W){1'b0}}, cfg_mode} < 32'(NUM_MODES));

  assign cfg_ready = (r_state == IDLE);
  assign pending   = (r_state == PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_mode  <= '0;
      r_auto_cnt  <= '0;
      mode_out    <= '0;
      mode_update <= 1'b0;
      cfg_err     <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      mode_update <= 1'b0;
      cfg_err     <= 1'b0;

      if (w_frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      // Disabling auto-cycle zeroes the counter so re-enable gets a full period
      if (!auto_en) begin
        r_auto_cnt <= '0;
      end

      case (r_state)
        IDLE: begin
          if (w_frame_start && auto_en) begin
            if (r_auto_cnt == c_auto_last) begin
              mode_out    <= (mode_out == c_mode_last) ? '0 : mode_out + MODE_W'(1);
              mode_update <= 1'b1;
              r_auto_cnt  <= '0;
            end else begin
              r_auto_cnt <= r_auto_cnt + CNT_W'(1);
            end
          end
          // A request taken on a frame_start edge only latches; it waits a full frame
          if (cfg_valid) begin
            if (w_mode_legal) begin
              r_req_mode <= cfg_mode;
              r_state    <= PEND;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        PEND: begin
          if (w_frame_start) begin
            mode_out    <= r_req_mode;
            mode_update <= 1'b1;
            r_auto_cnt  <= '0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
